// File: rtl/udp_rx_if.sv
// Signal bundle between the IP RX layer, the UDP receiver and its two consumers.
// The slave modport is the receiver's view; the master modport is the environment's view.
interface udp_rx_if #(
   parameter int unsigned AXI_DATA_WIDTH = 8
);
   // Datagram input stream from the IP layer
   logic [AXI_DATA_WIDTH-1:0] s_rx_axis_tdata;
   logic                      s_rx_axis_tvalid;
   logic                      s_rx_axis_tlast;
   logic                      s_rx_axis_trdy;

   // Decoded header channel
   logic                      m_udp_hdr_tvalid;
   logic                      m_udp_hdr_trdy;
   logic [15:0]               m_udp_src_port;
   logic [15:0]               m_udp_dst_port;
   logic [15:0]               m_udp_length;
   logic [15:0]               m_udp_checksum;

   // Payload output stream
   logic [AXI_DATA_WIDTH-1:0] m_rx_axis_tdata;
   logic                      m_rx_axis_tvalid;
   logic                      m_rx_axis_tlast;
   logic                      m_rx_axis_tuser;
   logic                      m_rx_axis_trdy;

   modport slave (
      input  s_rx_axis_tdata, s_rx_axis_tvalid, s_rx_axis_tlast,
      output s_rx_axis_trdy,
      output m_udp_hdr_tvalid, m_udp_src_port, m_udp_dst_port, m_udp_length, m_udp_checksum,
      input  m_udp_hdr_trdy,
      output m_rx_axis_tdata, m_rx_axis_tvalid, m_rx_axis_tlast, m_rx_axis_tuser,
      input  m_rx_axis_trdy
   );

   modport master (
      output s_rx_axis_tdata, s_rx_axis_tvalid, s_rx_axis_tlast,
      input  s_rx_axis_trdy,
      input  m_udp_hdr_tvalid, m_udp_src_port, m_udp_dst_port, m_udp_length, m_udp_checksum,
      output m_udp_hdr_trdy,
      input  m_rx_axis_tdata, m_rx_axis_tvalid, m_rx_axis_tlast, m_rx_axis_tuser,
      output m_rx_axis_trdy
   );
endinterface

// File: rtl/udp_rx.sv
// UDP receive de-encapsulator: strips the 8-byte header onto a valid/ready header channel,
// forwards the payload through a one-stage register slice and flags length mismatches in tuser.
module udp_rx #(
   parameter int unsigned AXI_DATA_WIDTH = 8
) (
   input  logic     i_clk,
   input  logic     i_reset,
   udp_rx_if.slave  bus,
   output logic     o_hdr_err
);

   typedef enum logic [1:0] {StHdr, StPayload, StDrop} state_t;

   state_t                    state;
   logic                      run;        // low during and right after reset so trdy reads 0
   logic [2:0]                hdr_cnt;
   logic [55:0]               hdr_sh;     // header bytes 0..6, oldest in the top byte
   logic [15:0]               pay_cnt;
   logic                      hdr_valid;
   logic [15:0]               src_port;
   logic [15:0]               dst_port;
   logic [15:0]               udp_len;
   logic [15:0]               csum;
   logic [AXI_DATA_WIDTH-1:0] pay_data;
   logic                      pay_valid;
   logic                      pay_last;
   logic                      pay_user;
   logic                      hdr_err;

   logic                      in_rdy;
   logic                      in_fire;
   logic [16:0]               total;
   logic                      len_bad;

   // Input ready per state, and the length check for the beat currently being accepted
   always_comb begin
      in_rdy = 1'b0;
      case (state)
         StHdr:     in_rdy = run & ~hdr_valid;
         StPayload: in_rdy = run & (~pay_valid | bus.m_rx_axis_trdy);
         default:   in_rdy = run;
      endcase
      in_fire = in_rdy & bus.s_rx_axis_tvalid;
      // 17 bits so a saturated counter still compares as larger than any 16-bit length
      total   = {1'b0, pay_cnt} + 17'd9;
      len_bad = (total != {1'b0, udp_len}) | (udp_len < 16'd8);
   end

   // Receive FSM with registered header fields and payload slice
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state     <= StHdr;
         run       <= 1'b0;
         hdr_cnt   <= 3'd0;
         hdr_sh    <= '0;
         pay_cnt   <= 16'd0;
         hdr_valid <= 1'b0;
         src_port  <= 16'd0;
         dst_port  <= 16'd0;
         udp_len   <= 16'd0;
         csum      <= 16'd0;
         pay_data  <= '0;
         pay_valid <= 1'b0;
         pay_last  <= 1'b0;
         pay_user  <= 1'b0;
         hdr_err   <= 1'b0;
      end else begin
         run     <= 1'b1;
         hdr_err <= 1'b0;

         if (hdr_valid && bus.m_udp_hdr_trdy) begin
            hdr_valid <= 1'b0;
         end

         // Drain the slice; a load below in the same cycle takes precedence
         if (pay_valid && bus.m_rx_axis_trdy) begin
            pay_valid <= 1'b0;
            pay_last  <= 1'b0;
            pay_user  <= 1'b0;
         end

         case (state)
            StHdr: begin
               if (in_fire) begin
                  if (hdr_cnt == 3'd7) begin
                     {src_port, dst_port, udp_len, csum} <= {hdr_sh, bus.s_rx_axis_tdata[7:0]};
                     hdr_valid <= 1'b1;
                     hdr_cnt   <= 3'd0;
                     pay_cnt   <= 16'd0;
                     // tlast here means a header-only datagram: stay waiting for the next one
                     if (!bus.s_rx_axis_tlast) begin
                        state <= StPayload;
                     end
                  end else if (bus.s_rx_axis_tlast) begin
                     hdr_err <= 1'b1;
                     hdr_cnt <= 3'd0;
                  end else begin
                     hdr_sh  <= {hdr_sh[47:0], bus.s_rx_axis_tdata[7:0]};
                     hdr_cnt <= hdr_cnt + 3'd1;
                  end
               end
            end

            StPayload: begin
               if (in_fire) begin
                  pay_data  <= bus.s_rx_axis_tdata;
                  pay_valid <= 1'b1;
                  pay_last  <= bus.s_rx_axis_tlast;
                  pay_user  <= bus.s_rx_axis_tlast & len_bad;
                  if (pay_cnt != 16'hFFFF) begin
                     pay_cnt <= pay_cnt + 16'd1;
                  end
                  if (bus.s_rx_axis_tlast) begin
                     state <= StHdr;
                  end
               end
            end

            // Reserved discard state: swallow the rest of the datagram silently
            StDrop: begin
               if (in_fire && bus.s_rx_axis_tlast) begin
                  state <= StHdr;
               end
            end

            default: state <= StHdr;
         endcase
      end
   end

   assign bus.s_rx_axis_trdy   = in_rdy;
   assign bus.m_udp_hdr_tvalid = hdr_valid;
   assign bus.m_udp_src_port   = src_port;
   assign bus.m_udp_dst_port   = dst_port;
   assign bus.m_udp_length     = udp_len;
   assign bus.m_udp_checksum   = csum;
   assign bus.m_rx_axis_tdata  = pay_data;
   assign bus.m_rx_axis_tvalid = pay_valid;
   assign bus.m_rx_axis_tlast  = pay_last;
   assign bus.m_rx_axis_tuser  = pay_user;
   assign o_hdr_err            = hdr_err;

endmodule

// File: doc/udp_rx.md
Name: udp_rx

Overview:
Receive-side counterpart of the UDP transmit encapsulator. Accepts a UDP datagram (8-byte header plus payload) as a byte-wide AXI-Stream from the IP RX layer and strips the header. Presents source port, destination port, length and checksum on a separate valid/ready header channel, and forwards the payload on an AXI-Stream master. Checksum is passed through unverified; length consistency is checked and flagged on the last payload beat.

Parameters:
AXI_DATA_WIDTH, 8, stream data width in bits; only 8 is supported.

Ports:
i_clk  input  1  system clock, all logic on rising edge
i_reset  input  1  asynchronous active-high reset
s_rx_axis_tdata  input  AXI_DATA_WIDTH  incoming UDP datagram byte
s_rx_axis_tvalid  input  1  input byte valid
s_rx_axis_tlast  input  1  last byte of datagram
s_rx_axis_trdy  output  1  input ready
m_udp_hdr_tvalid  output  1  decoded header fields valid
m_udp_hdr_trdy  input  1  header consumer ready
m_udp_src_port  output  16  source port
m_udp_dst_port  output  16  destination port
m_udp_length  output  16  UDP length field (header + payload bytes)
m_udp_checksum  output  16  UDP checksum field, unverified
m_rx_axis_tdata  output  AXI_DATA_WIDTH  payload byte
m_rx_axis_tvalid  output  1  payload byte valid
m_rx_axis_tlast  output  1  last payload byte
m_rx_axis_tuser  output  1  on the tlast beat only: 1 = length mismatch
m_rx_axis_trdy  input  1  payload consumer ready
o_hdr_err  output  1  one-cycle pulse: datagram truncated inside header

Behaviour:
- Reset (asynchronous, any state): state=HDR, counters=0, and all outputs 0. This covers s_rx_axis_trdy, both tvalids, tlast, tuser, o_hdr_err and all header fields. A datagram in flight at reset is abandoned; no partial output follows.
- Transfer occurs on tvalid & trdy at a rising edge. A master never drops tvalid or changes data until the beat is accepted.
- States: HDR, PAYLOAD, DROP.
- HDR:
  - s_rx_axis_trdy = !m_udp_hdr_tvalid, so a new header is never captured over an unconsumed one.
  - A 3-bit hdr_cnt counts accepted bytes. Fields are big-endian: bytes 0-1 src, 2-3 dst, 4-5 length, 6-7 checksum.
- Byte 7 accepted:
  - Next cycle, fields are updated and m_udp_hdr_tvalid=1. It holds until m_udp_hdr_trdy, then clears the following cycle.
  - If tlast on byte 7 (zero-length payload): go to HDR. No payload beat is emitted. The header is still emitted.
  - Else: pay_cnt=0, go to PAYLOAD.
- tlast on bytes 0-6: discard, o_hdr_err pulses next cycle, no header emitted, hdr_cnt=0, stay HDR.
- PAYLOAD:
  - One-stage register slice, 1-cycle latency: s_rx_axis_trdy = !m_rx_axis_tvalid | m_rx_axis_trdy.
  - Each accepted byte loads tdata/tlast, sets m_rx_axis_tvalid and increments the 16-bit pay_cnt.
  - Payload flow is independent of header-channel acceptance.
- Input tlast in PAYLOAD:
  - m_rx_axis_tuser = ((pay_cnt+1) + 8 != m_udp_length) | (m_udp_length < 8), computed with 17-bit arithmetic.
  - Go to HDR. The next header can be accepted while this last beat is still pending on the output.
- pay_cnt saturates at 16'hFFFF. A datagram exceeding it is forwarded with tuser=1 on its last beat.
- Ethernet padding is trimmed upstream. Excess bytes are not trimmed here; they are forwarded and flagged through tuser.
- DROP: entered from PAYLOAD only if the payload register is stalled when a header-pending overflow would occur. It is reserved and unreachable in nominal operation. It consumes input with trdy=1 until tlast, then goes to HDR with no output.
- Simultaneous m_udp_hdr_trdy and a new header completion cannot occur, because trdy gating prevents it.
- m_rx_axis_tuser=0 on non-last beats.

Test Plan:
1. Input 04 D2 16 2E 00 0C AB CD 11 22 33 44 (tlast on 44), all readies=1:
   - Header src=0x04D2, dst=0x162E, len=0x000C, csum=0xABCD.
   - Payload 11 22 33 44, tlast on 44, tuser=0.
   - First payload beat appears 1 cycle after byte 8 is accepted.
2. Same stream with length=0x000D:
   - Identical payload, tuser=1 on 44.
3. Header-only datagram 00 35 00 35 00 08 00 00 with tlast on byte 7:
   - Header emitted with len=8.
   - No m_rx_axis_tvalid ever asserted.
   - Immediately followed by datagram 1, which decodes correctly.
4. Truncated header 01 02 03 04 05 with tlast on 05:
   - o_hdr_err one-cycle pulse, no header or payload outputs.
   - A following valid datagram decodes correctly.
5. Backpressure:
   - m_rx_axis_trdy toggles 1010…; no bytes lost or duplicated, order preserved.
   - With m_udp_hdr_trdy held 0, a second datagram stalls at byte 0 (s_rx_axis_trdy=0) until the header is accepted.
6. Assert i_reset asynchronously mid-payload (between clock edges):
   - All outputs 0 immediately, without waiting for a clock edge.
   - After release, datagram 1 is received cleanly.
